// File: rtl/hc_pkg.sv
// hc_pkg: shared buffer command/status types and defaults for the hc buffer bank.
package hc_pkg;
  typedef enum logic [1:0] {
    e_BUFFER_IDLE    = 2'd0,
    e_BUFFER_ENQUEUE = 2'd1,
    e_BUFFER_DEQUEUE = 2'd2,
    e_BUFFER_ENQ_DEQ = 2'd3
  } t_buffer_cmd;
  localparam int HC_BUFFER_DEPTH     = 16;
  localparam int HC_BUFFER_AF_THRESH = HC_BUFFER_DEPTH - 2;
  typedef struct packed {
    logic empty;
    logic full;
    logic almost_full;
    logic overflow;
    logic underflow;
  } t_buffer_status;
  function automatic bit is_pow2(int v);
    return v >= 2 && (v & (v - 1)) == 0;
  endfunction
endpackage

// File: rtl/hc_buffer_fifo.sv
// hc_buffer_fifo: single-channel first-word fall-through FIFO with command decode and sticky status.
module hc_buffer_fifo
  import hc_pkg::*;
#(
  parameter int DEPTH      = HC_BUFFER_DEPTH,
  parameter int DATA_WIDTH = 512,
  parameter int AF_THRESH  = HC_BUFFER_AF_THRESH,
  localparam int CW = $clog2(DEPTH) + 1,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  t_buffer_cmd           cmd,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [CW-1:0]         count,
  output t_buffer_status        status
);
  if (!is_pow2(DEPTH)) begin : g_bad_depth
    $error("hc_buffer_fifo: DEPTH must be a power of two >= 2");
  end
  if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af
    $error("hc_buffer_fifo: AF_THRESH must be in 1..DEPTH");
  end
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]         wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]         count_q, count_d;
  t_buffer_status        status_q, status_d;
  logic                  enq, deq, do_enq, do_deq;
  // a full buffer still accepts a write when the same cycle pops the head
  always_comb begin
    enq                   = cmd == e_BUFFER_ENQUEUE || cmd == e_BUFFER_ENQ_DEQ;
    deq                   = cmd == e_BUFFER_DEQUEUE || cmd == e_BUFFER_ENQ_DEQ;
    do_deq                = deq && !status_q.empty && !clear;
    do_enq                = enq && (!status_q.full || deq) && !clear;
    wptr_d                = clear ? '0 : wptr_q + AW'(do_enq);
    rptr_d                = clear ? '0 : rptr_q + AW'(do_deq);
    count_d               = clear ? '0 : count_q + CW'(do_enq) - CW'(do_deq);
    status_d.empty        = count_d == '0;
    status_d.full         = count_d == CW'(DEPTH);
    status_d.almost_full  = count_d >= CW'(AF_THRESH);
    status_d.overflow     = !clear && (status_q.overflow || (enq && !deq && status_q.full));
    status_d.underflow    = !clear && (status_q.underflow || (deq && status_q.empty));
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
      status_q <= '{empty: 1'b1, default: 1'b0};
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      count_q  <= count_d;
      status_q <= status_d;
    end
  end
  always_ff @(posedge clk) begin
    if (do_enq) mem_q[wptr_q] <= wr_data;
  end
  assign rd_data = mem_q[rptr_q];
  assign count   = count_q;
  assign status  = status_q;
endmodule

// File: rtl/hc_buffer_bank.sv
// hc_buffer_bank: N independent FIFO buffers with per-buffer command, data and status buses.
module hc_buffer_bank
  import hc_pkg::*;
#(
  parameter int N_BUFFERS  = 4,
  parameter int DEPTH      = HC_BUFFER_DEPTH,
  parameter int DATA_WIDTH = 512,
  parameter int AF_THRESH  = DEPTH - 2,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [2*N_BUFFERS-1:0]          cmd,
  input  logic [N_BUFFERS-1:0]            clear,
  input  logic [DATA_WIDTH*N_BUFFERS-1:0] wr_data,
  output logic [DATA_WIDTH*N_BUFFERS-1:0] rd_data,
  output logic [CW*N_BUFFERS-1:0]         count,
  output logic [N_BUFFERS-1:0]            empty,
  output logic [N_BUFFERS-1:0]            full,
  output logic [N_BUFFERS-1:0]            almost_full,
  output logic [N_BUFFERS-1:0]            overflow,
  output logic [N_BUFFERS-1:0]            underflow
);
  for (genvar i = 0; i < N_BUFFERS; i++) begin : g_buf
    t_buffer_status st;
    hc_buffer_fifo #(
      .DEPTH(DEPTH),
      .DATA_WIDTH(DATA_WIDTH),
      .AF_THRESH(AF_THRESH)
    ) u_fifo (
      .clk(clk),
      .reset(reset),
      .clear(clear[i]),
      .cmd(t_buffer_cmd'(cmd[2*i +: 2])),
      .wr_data(wr_data[DATA_WIDTH*i +: DATA_WIDTH]),
      .rd_data(rd_data[DATA_WIDTH*i +: DATA_WIDTH]),
      .count(count[CW*i +: CW]),
      .status(st)
    );
    assign empty[i]       = st.empty;
    assign full[i]        = st.full;
    assign almost_full[i] = st.almost_full;
    assign overflow[i]    = st.overflow;
    assign underflow[i]   = st.underflow;
  end
endmodule

// File: tb/tb_hc_buffer_bank.sv
// tb_hc_buffer_bank: scenario tasks plus randomized traffic against a queue-based reference model.
module tb_hc_buffer_bank;
  localparam int N = 4, D = 8, W = 32, AF = 6, CW = 4;
  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [2*N-1:0]   cmd = '0;
  logic [N-1:0]     clear = '0;
  logic [W*N-1:0]   wr_data = '0;
  logic [W*N-1:0]   rd_data;
  logic [CW*N-1:0]  count;
  logic [N-1:0]     empty, full, almost_full, overflow, underflow;
  int               n_cmp = 0, n_fail = 0;
  logic [W-1:0]     mq [N][$];
  bit               m_ovf [N];
  bit               m_unf [N];
  localparam logic [8:0] RST_ST = {4'd0, 1'b1, 4'b0000};

  hc_buffer_bank #(.N_BUFFERS(N), .DEPTH(D), .DATA_WIDTH(W), .AF_THRESH(AF)) dut (
    .clk(clk), .reset(reset), .cmd(cmd), .clear(clear), .wr_data(wr_data),
    .rd_data(rd_data), .count(count), .empty(empty), .full(full),
    .almost_full(almost_full), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  task automatic set_cmd(int i, logic [1:0] c, logic [W-1:0] d);
    cmd[2*i +: 2]  = c;
    wr_data[W*i +: W] = d;
  endtask

  task automatic idle_all();
    cmd   = '0;
    clear = '0;
  endtask

  // reference model: a queue per buffer, updated from the inputs seen at the edge
  task automatic tick();
    logic [1:0] c;
    @(posedge clk);
    for (int i = 0; i < N; i++) begin
      c = cmd[2*i +: 2];
      if (reset || clear[i]) begin
        mq[i].delete();
        m_ovf[i] = 0;
        m_unf[i] = 0;
      end else begin
        if (c[1]) begin
          if (mq[i].size() == 0) m_unf[i] = 1;
          else void'(mq[i].pop_front());
        end
        if (c[0]) begin
          if (mq[i].size() < D) mq[i].push_back(wr_data[W*i +: W]);
          else m_ovf[i] = 1;
        end
      end
    end
    #1;
  endtask

  function automatic logic [8:0] exp_st(int i);
    int s = mq[i].size();
    return {4'(s), 1'(s == 0), 1'(s == D), 1'(s >= AF), 1'(m_ovf[i]), 1'(m_unf[i])};
  endfunction

  function automatic logic [8:0] obs_st(int i);
    return {count[CW*i +: CW], empty[i], full[i], almost_full[i], overflow[i], underflow[i]};
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    idle_all();
    tick();
    tick();
    reset = 1'b0;
    repeat (3) tick();
    for (int i = 0; i < N; i++) begin
      n_cmp++;
      if (obs_st(i) !== RST_ST) begin
        n_fail++;
        $display("FAIL reset buf%0d status: got %h want %h", i, obs_st(i), RST_ST);
      end
    end
  endtask

  task automatic test_fill_drain();
    logic [5:0] want;
    for (int k = 0; k < 8; k++) begin
      set_cmd(0, 2'd1, 32'h10 + k);
      tick();
      want = {4'(k + 1), 1'(k >= 5), 1'(k == 7)};
      n_cmp++;
      if ({count[3:0], almost_full[0], full[0]} !== want) begin
        n_fail++;
        $display("FAIL fill step%0d {count,af,full}: got %h want %h", k, {count[3:0], almost_full[0], full[0]}, want);
      end
    end
    set_cmd(0, 2'd1, 32'hFF);
    tick();
    n_cmp++;
    if ({overflow[0], count[3:0]} !== 5'b1_1000) begin
      n_fail++;
      $display("FAIL overflow {ovf,count}: got %h want %h", {overflow[0], count[3:0]}, 5'b1_1000);
    end
    for (int k = 0; k < 8; k++) begin
      n_cmp++;
      if (rd_data[31:0] !== 32'h10 + k) begin
        n_fail++;
        $display("FAIL drain rd_data%0d: got %h want %h", k, rd_data[31:0], 32'h10 + k);
      end
      set_cmd(0, 2'd2, '0);
      tick();
    end
    set_cmd(0, 2'd0, '0);
    n_cmp++;
    if ({empty[0], count[3:0], underflow[0]} !== 6'b1_0000_0) begin
      n_fail++;
      $display("FAIL drained {empty,count,unf}: got %h want %h", {empty[0], count[3:0], underflow[0]}, 6'b100000);
    end
  endtask

  task automatic test_wrap();
    for (int r = 0; r < 5; r++) begin
      for (int j = 0; j < 4; j++) begin
        set_cmd(1, 2'd1, $urandom);
        tick();
      end
      set_cmd(1, 2'd0, '0);
      n_cmp++;
      if (count[7:4] !== 4'd4 || count[7:4] > 4'd8) begin
        n_fail++;
        $display("FAIL wrap round%0d count: got %0d want 4", r, count[7:4]);
      end
      for (int j = 0; j < 4; j++) begin
        n_cmp++;
        if (rd_data[63:32] !== mq[1][0]) begin
          n_fail++;
          $display("FAIL wrap round%0d order%0d: got %h want %h", r, j, rd_data[63:32], mq[1][0]);
        end
        set_cmd(1, 2'd2, '0);
        tick();
      end
      set_cmd(1, 2'd0, '0);
    end
    n_cmp++;
    if (obs_st(1) !== RST_ST) begin
      n_fail++;
      $display("FAIL wrap end status: got %h want %h", obs_st(1), RST_ST);
    end
  endtask

  task automatic test_enq_deq();
    logic [W-1:0] want;
    for (int k = 0; k < 8; k++) begin
      set_cmd(2, 2'd1, 32'hA0 + k);
      tick();
    end
    set_cmd(2, 2'd3, 32'hB0);
    set_cmd(3, 2'd3, 32'hC0);
    tick();
    idle_all();
    n_cmp++;
    if ({count[11:8], full[2], overflow[2]} !== {4'd8, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL enqdeq-full {count,full,ovf}: got %h want %h", {count[11:8], full[2], overflow[2]}, {4'd8, 2'b10});
    end
    n_cmp++;
    if (rd_data[95:64] !== 32'hA1) begin
      n_fail++;
      $display("FAIL enqdeq-full head: got %h want %h", rd_data[95:64], 32'hA1);
    end
    n_cmp++;
    if ({count[15:12], empty[3], underflow[3]} !== {4'd1, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL enqdeq-empty {count,empty,unf}: got %h want %h", {count[15:12], empty[3], underflow[3]}, {4'd1, 2'b01});
    end
    n_cmp++;
    if (rd_data[127:96] !== 32'hC0) begin
      n_fail++;
      $display("FAIL enqdeq-empty head: got %h want %h", rd_data[127:96], 32'hC0);
    end
    for (int k = 0; k < 8; k++) begin
      want = (k < 7) ? 32'hA1 + k : 32'hB0;
      n_cmp++;
      if (rd_data[95:64] !== want) begin
        n_fail++;
        $display("FAIL enqdeq drain%0d: got %h want %h", k, rd_data[95:64], want);
      end
      set_cmd(2, 2'd2, '0);
      tick();
    end
    idle_all();
  endtask

  task automatic test_clear();
    for (int k = 0; k < 9; k++) begin
      set_cmd(1, 2'd1, $urandom);
      tick();
    end
    for (int k = 0; k < 5; k++) begin
      set_cmd(1, 2'd2, '0);
      tick();
    end
    n_cmp++;
    if ({count[7:4], overflow[1]} !== {4'd3, 1'b1}) begin
      n_fail++;
      $display("FAIL clear setup {count,ovf}: got %h want %h", {count[7:4], overflow[1]}, {4'd3, 1'b1});
    end
    set_cmd(1, 2'd1, 32'hDD);
    clear = 4'b0010;
    tick();
    idle_all();
    n_cmp++;
    if (obs_st(1) !== RST_ST) begin
      n_fail++;
      $display("FAIL clear buf1 status: got %h want %h", obs_st(1), RST_ST);
    end
    tick();
    n_cmp++;
    if (count[7:4] !== 4'd0) begin
      n_fail++;
      $display("FAIL clear discards enqueue count: got %0d want 0", count[7:4]);
    end
    for (int i = 0; i < N; i++) begin
      if (i == 1) continue;
      n_cmp++;
      if (obs_st(i) !== exp_st(i)) begin
        n_fail++;
        $display("FAIL clear neighbour buf%0d: got %h want %h", i, obs_st(i), exp_st(i));
      end
    end
    n_cmp++;
    if (rd_data[127:96] !== 32'hC0) begin
      n_fail++;
      $display("FAIL clear neighbour buf3 head: got %h want %h", rd_data[127:96], 32'hC0);
    end
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < N; i++) set_cmd(i, 2'd1, $urandom);
      tick();
    end
    for (int i = 0; i < N; i++) begin
      n_cmp++;
      if (obs_st(i) !== exp_st(i)) begin
        n_fail++;
        $display("FAIL pre-reset buf%0d: got %h want %h", i, obs_st(i), exp_st(i));
      end
    end
    reset = 1'b1;
    clear = 4'b0101;
    tick();
    reset = 1'b0;
    idle_all();
    for (int i = 0; i < N; i++) begin
      n_cmp++;
      if (obs_st(i) !== RST_ST) begin
        n_fail++;
        $display("FAIL mid-reset buf%0d: got %h want %h", i, obs_st(i), RST_ST);
      end
    end
  endtask

  task automatic test_random();
    int r;
    logic [1:0] c;
    for (int t = 0; t < 600; t++) begin
      for (int i = 0; i < N; i++) begin
        r = $urandom_range(0, 7);
        c = (r < 3) ? 2'd1 : (r < 5) ? 2'd3 : (r < 7) ? 2'd2 : 2'd0;
        if ((t / 60) % 2 == 1 && c != 2'd3 && c != 2'd0) c = ~c;
        set_cmd(i, c, $urandom);
        clear[i] = ($urandom_range(0, 31) == 0);
      end
      reset = ($urandom_range(0, 127) == 0);
      tick();
      for (int i = 0; i < N; i++) begin
        n_cmp++;
        if (obs_st(i) !== exp_st(i)) begin
          n_fail++;
          $display("FAIL random t%0d buf%0d status: got %h want %h", t, i, obs_st(i), exp_st(i));
        end
        if (mq[i].size() > 0) begin
          n_cmp++;
          if (rd_data[W*i +: W] !== mq[i][0]) begin
            n_fail++;
            $display("FAIL random t%0d buf%0d rd_data: got %h want %h", t, i, rd_data[W*i +: W], mq[i][0]);
          end
        end
      end
    end
    reset = 1'b0;
    idle_all();
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_wrap();
    test_enq_deq();
    test_clear();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/hc_buffer_bank.md
Name: hc_buffer_bank

Overview:
Parametrised bank of N independent FIFO buffers. Each buffer is driven by its own per-buffer command (idle, enqueue, dequeue, or combined enqueue+dequeue) and reports count, empty, full, almost-full and sticky overflow/underflow status. It replaces the fixed-size per-buffer storage behind the buffer command/status interface. It sits between the AFU datapath and the read/write request engines.

Parameters:
- N_BUFFERS, 4, number of independent buffers (>=1)
- DEPTH, 16, entries per buffer; power of two, >=2
- DATA_WIDTH, 512, bits per entry (one cache line)
- AF_THRESH, DEPTH-2, almost_full asserts when count >= AF_THRESH; range 1..DEPTH
- CW (localparam), $clog2(DEPTH)+1, count width

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- cmd  in  2*N_BUFFERS  per-buffer command: 0 IDLE, 1 ENQUEUE, 2 DEQUEUE, 3 ENQ_DEQ
- clear  in  N_BUFFERS  per-buffer flush; priority over cmd
- wr_data  in  DATA_WIDTH*N_BUFFERS  per-buffer enqueue data, sampled with ENQUEUE/ENQ_DEQ
- rd_data  out  DATA_WIDTH*N_BUFFERS  per-buffer head entry (first-word fall-through)
- count  out  CW*N_BUFFERS  entries held, 0..DEPTH
- empty  out  N_BUFFERS  count==0
- full  out  N_BUFFERS  count==DEPTH
- almost_full  out  N_BUFFERS  count>=AF_THRESH
- overflow  out  N_BUFFERS  sticky: enqueue attempted while full and not accepted
- underflow  out  N_BUFFERS  sticky: dequeue attempted while empty

Behaviour:
- Reset values, all buffers: count=0, empty=1, full=0, almost_full=0, overflow=0, underflow=0. Read/write pointers are 0. Storage is not reset. rd_data is don't-care while empty.
- Buffers are fully independent. No arbitration between buffers. All N may act in the same cycle.
- Status outputs are registered. A command sampled at edge k is reflected in count/flags/rd_data after edge k (zero-wait, one-cycle latency).
- rd_data always shows the entry at the read pointer. After a dequeue at edge k, the next entry is visible after edge k.
- ENQUEUE, not full: write wr_data at wptr; wptr += 1 mod DEPTH; count += 1.
- ENQUEUE, full: data dropped; state unchanged; overflow <= 1.
- DEQUEUE, not empty: rptr += 1 mod DEPTH; count -= 1.
- DEQUEUE, empty: state unchanged; underflow <= 1.
- ENQ_DEQ, 0<count<DEPTH: write and pop in the same cycle; count unchanged; both pointers advance.
- ENQ_DEQ, full: pop of the head and write to the freed slot are both accepted; count stays DEPTH; no overflow.
- ENQ_DEQ, empty: enqueue accepted (count becomes 1); dequeue ignored; underflow <= 1. The written value is not bypassed to rd_data in the same cycle.
- Pointer wrap: DEPTH is a power of two, so pointers are $clog2(DEPTH) bits and wrap naturally.
- Full and empty are decided from count, not from pointer equality.
- clear[i]: next cycle, buffer i has pointers=0, count=0, empty=1, and overflow/underflow cleared. cmd[i] in the same cycle is ignored.
- Sticky flags clear only on reset or clear.
- reset mid-operation: returns every buffer to reset state on the next edge, regardless of cmd or clear. In-flight data is lost.
- Illegal parameters (DEPTH not a power of two, AF_THRESH out of range): elaboration-time $error.

Decomposition:
- hc_pkg gains:
  - t_buffer_cmd enum: e_BUFFER_IDLE, e_BUFFER_ENQUEUE, e_BUFFER_DEQUEUE, e_BUFFER_ENQ_DEQ (2 bits)
  - HC_BUFFER_DEPTH and HC_BUFFER_AF_THRESH defaults
  - t_buffer_status extended with almost_full, overflow, underflow
- One sub-module, hc_buffer_fifo: a single-channel FIFO with the command decode, pointers, count and flags above. The bank is a generate loop of N_BUFFERS instances plus bus slicing.

Test Plan (N_BUFFERS=4, DEPTH=8, DATA_WIDTH=32, AF_THRESH=6):
1. Reset, then idle 3 cycles -> all count=0, empty=1, full=0, almost_full=0, overflow=0, underflow=0.
2. Buffer 0: ENQUEUE 0x10..0x17 on 8 consecutive cycles -> almost_full rises after the 6th, full after the 8th. A 9th ENQUEUE of 0xFF -> overflow=1, count=8. Then 8 DEQUEUEs -> rd_data sequence 0x10..0x17, then empty=1.
3. Buffer 1: 5 ENQUEUE/DEQUEUE cycles pushing 20 values total -> pointers wrap twice; output order preserved; count never exceeds 8.
4. Buffer 2 full (8 entries, head 0xA0): ENQ_DEQ with 0xB0 -> count stays 8, overflow=0, rd_data becomes the second entry. Buffer 3 empty: ENQ_DEQ with 0xC0 -> count=1, rd_data=0xC0 next cycle, underflow=1.
5. Buffer 1 holding 3 entries with overflow set: clear[1]=1 together with cmd[1]=ENQUEUE -> next cycle count=0, empty=1, overflow=0, enqueue discarded. Buffers 0/2/3 are unaffected.
6. All 4 buffers ENQUEUE for 4 cycles, then reset=1 for 1 cycle while cmd=ENQUEUE -> every buffer returns to count=0, empty=1, and all flags cleared.
